rpsc_hv_sequencer: RTL and testbench

RPSC_HV_SEQUENCER -- requirements
Module: rpsc_hv_sequencer

---
 rtl/rpsc_hv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_rpsc_hv_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpsc_hv_sequencer.sv
// HV supply sequencer: debounces active-low permissives, ramps G2 then anode
// up and down, and latches the offending permissive vector on a trip.
module rpsc_hv_sequencer #(
  parameter int N_PERM   = 3,
  parameter int DEB_CYC  = 4,
  parameter int RAMP_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PERM-1:0] i_perm_b,
  input  logic              i_hv_req,
  input  logic              i_fault_clr,
  input  logic              i_rf_perm,
  output logic              o_sb_on_b,
  output logic              o_sb_off_b,
  output logic              o_g2_en,
  output logic              o_anode_en,
  output logic              o_hv_on,
  output logic              o_hv_on_b,
  output logic              o_hv_ready,
  output logic              o_rf_perm,
  output logic              o_fault,
  output logic [N_PERM-1:0] o_fault_src
);

  typedef enum logic [2:0] {IDLE, G2_UP, RUN, G2_DOWN, FAULT} state_t;

  logic [N_PERM-1:0] sync1_q, sync2_q, deb_q, deb_d;
  logic              perm_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
    end else begin
      sync1_q <= i_perm_b;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
    end
  end

  // Per-bit stability counter; any agreement with the debounced value restarts it.
  genvar gi;
  generate
    for (gi = 0; gi < N_PERM; gi++) begin : g_deb
      logic [7:0] cnt_q, cnt_d;
      logic       bit_d;

      always_comb begin
        bit_d = deb_q[gi];
        cnt_d = '0;
        if (sync2_q[gi] != deb_q[gi]) begin
          if (cnt_q == 8'(DEB_CYC - 1)) begin
            bit_d = sync2_q[gi];
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign deb_d[gi] = bit_d;
    end
  endgenerate

  assign perm_ok = ~|deb_q;

  state_t            state_q, state_d;
  logic [7:0]        ramp_q, ramp_d;
  logic [N_PERM-1:0] src_q, src_d;

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (i_hv_req && perm_ok) begin
          state_d = G2_UP;
          ramp_d  = '0;
        end
      end
      G2_UP: begin
        if (!i_hv_req) begin
          state_d = G2_DOWN;
          ramp_d  = '0;
        end else if (ramp_q == 8'(RAMP_CYC - 1)) begin
          state_d = RUN;
        end else begin
          ramp_d = ramp_q + 8'd1;
        end
      end
      RUN: begin
        if (!i_hv_req) begin
          state_d = G2_DOWN;
          ramp_d  = '0;
        end
      end
      G2_DOWN: begin
        if (ramp_q == 8'(RAMP_CYC - 1)) state_d = IDLE;
        else                            ramp_d  = ramp_q + 8'd1;
      end
      FAULT: begin
        // Requiring hv_req low here forces a fresh request through IDLE.
        if (i_fault_clr && perm_ok && !i_hv_req) begin
          state_d = IDLE;
          src_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!perm_ok && (state_q == G2_UP || state_q == RUN || state_q == G2_DOWN)) begin
      state_d = FAULT;
      ramp_d  = '0;
      src_d   = deb_q;
    end
  end

  logic g2_d, anode_d, ready_d, rf_d, fault_d, sb_on_b_d;
  logic g2_q, anode_q, ready_q, rf_q, fault_q, sb_on_b_q;

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    g2_d      = (state_d == G2_UP) || (state_d == RUN) || (state_d == G2_DOWN);
    anode_d   = (state_d == RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
    rf_d      = i_rf_perm && ready_q && ready_d;
    sb_on_b_d = |deb_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ramp_q    <= '0;
      src_q     <= '0;
      g2_q      <= 1'b0;
      anode_q   <= 1'b0;
      ready_q   <= 1'b0;
      rf_q      <= 1'b0;
      fault_q   <= 1'b0;
      sb_on_b_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ramp_q    <= ramp_d;
      src_q     <= src_d;
      g2_q      <= g2_d;
      anode_q   <= anode_d;
      ready_q   <= ready_d;
      rf_q      <= rf_d;
      fault_q   <= fault_d;
      sb_on_b_q <= sb_on_b_d;
    end
  end

  assign o_sb_on_b   = sb_on_b_q;
  assign o_sb_off_b  = ~sb_on_b_q;
  assign o_g2_en     = g2_q;
  assign o_anode_en  = anode_q;
  assign o_hv_on     = g2_q | anode_q;
  assign o_hv_on_b   = ~(g2_q & anode_q);
  assign o_hv_ready  = ready_q;
  assign o_rf_perm   = rf_q;
  assign o_fault     = fault_q;
  assign o_fault_src = src_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Directed bench for rpsc_hv_sequencer with default parameters
// (3 permissives, 4-cycle debounce, 8-cycle ramp).
module tb_rpsc_hv_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] i_perm_b = 3'b111;
  logic       i_hv_req = 1'b0;
  logic       i_fault_clr = 1'b0;
  logic       i_rf_perm = 1'b0;
  logic       o_sb_on_b, o_sb_off_b, o_g2_en, o_anode_en, o_hv_on, o_hv_on_b;
  logic       o_hv_ready, o_rf_perm, o_fault;
  logic [2:0] o_fault_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rpsc_hv_sequencer #(.N_PERM(3), .DEB_CYC(4), .RAMP_CYC(8)) dut (
    .clk(clk), .reset(reset), .i_perm_b(i_perm_b), .i_hv_req(i_hv_req),
    .i_fault_clr(i_fault_clr), .i_rf_perm(i_rf_perm),
    .o_sb_on_b(o_sb_on_b), .o_sb_off_b(o_sb_off_b), .o_g2_en(o_g2_en),
    .o_anode_en(o_anode_en), .o_hv_on(o_hv_on), .o_hv_on_b(o_hv_on_b),
    .o_hv_ready(o_hv_ready), .o_rf_perm(o_rf_perm), .o_fault(o_fault),
    .o_fault_src(o_fault_src)
  );

  // Packs the outputs as {sb_on_b, sb_off_b, g2, anode, hv_on, hv_on_b, ready, rf, fault, src[2:0]}.
  function automatic logic [11:0] outs();
    return {o_sb_on_b, o_sb_off_b, o_g2_en, o_anode_en, o_hv_on, o_hv_on_b,
            o_hv_ready, o_rf_perm, o_fault, o_fault_src};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    cycles(2);
    n_checks++;
    if (outs() !== 12'b10_0001_000_000) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", outs(), 12'b10_0001_000_000);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_debounce();
    logic exp;
    i_perm_b = 3'b000;
    for (int n = 1; n <= 7; n++) begin
      cycles(1);
      exp = (n >= 6) ? 1'b0 : 1'b1;
      n_checks++;
      if (o_sb_on_b !== exp || o_sb_off_b !== ~exp) begin
        n_fail++;
        $display("FAIL debounce_cyc%0d sb_on_b=%b sb_off_b=%b want sb_on_b=%b", n, o_sb_on_b, o_sb_off_b, exp);
      end
    end
    $display("test_debounce done");
  endtask

  task automatic test_glitch();
    i_perm_b = 3'b010;
    cycles(3);
    i_perm_b = 3'b000;
    for (int n = 1; n <= 8; n++) begin
      cycles(1);
      n_checks++;
      if (o_sb_on_b !== 1'b0 || o_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_cyc%0d sb_on_b=%b fault=%b want 0 0", n, o_sb_on_b, o_fault);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_ramp_up();
    logic [3:0] exp;
    i_rf_perm = 1'b1;
    i_hv_req  = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      cycles(1);
      // {g2, anode, ready, rf}
      if (n < 9)       exp = 4'b1000;
      else if (n == 9) exp = 4'b1110;
      else             exp = 4'b1111;
      n_checks++;
      if ({o_g2_en, o_anode_en, o_hv_ready, o_rf_perm} !== exp ||
          o_hv_on !== 1'b1 || o_hv_on_b !== (n < 9)) begin
        n_fail++;
        $display("FAIL ramp_up_cyc%0d g2/an/rdy/rf=%b hv_on=%b hv_on_b=%b want %b 1 %b",
                 n, {o_g2_en, o_anode_en, o_hv_ready, o_rf_perm}, o_hv_on, o_hv_on_b, exp, (n < 9));
      end
    end
    $display("test_ramp_up done");
  endtask

  task automatic test_ramp_down();
    logic [2:0] exp;
    i_hv_req = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      cycles(1);
      // {g2, anode, hv_on}
      exp = (n < 9) ? 3'b101 : 3'b000;
      n_checks++;
      if ({o_g2_en, o_anode_en, o_hv_on} !== exp || o_hv_ready !== 1'b0 || o_rf_perm !== 1'b0) begin
        n_fail++;
        $display("FAIL ramp_down_cyc%0d g2/an/hv_on=%b rdy=%b rf=%b want %b 0 0",
                 n, {o_g2_en, o_anode_en, o_hv_on}, o_hv_ready, o_rf_perm, exp);
      end
    end
    $display("test_ramp_down done");
  endtask

  task automatic test_abort();
    i_hv_req = 1'b1;
    cycles(3);
    i_hv_req = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      cycles(1);
      n_checks++;
      if (o_g2_en !== (n < 9) || o_anode_en !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_cyc%0d g2=%b anode=%b want %b 0", n, o_g2_en, o_anode_en, (n < 9));
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_idle_no_fault();
    i_perm_b = 3'b001;
    cycles(8);
    i_hv_req = 1'b1;
    cycles(4);
    n_checks++;
    if (o_sb_on_b !== 1'b1 || o_fault !== 1'b0 || o_g2_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_fault sb_on_b=%b fault=%b g2=%b want 1 0 0", o_sb_on_b, o_fault, o_g2_en);
    end
    i_hv_req = 1'b0;
    i_perm_b = 3'b000;
    cycles(8);
    $display("test_idle_no_fault done");
  endtask

  task automatic test_fault();
    i_hv_req = 1'b1;
    cycles(9);
    n_checks++;
    if (o_hv_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_setup_run ready=%b want 1", o_hv_ready);
    end
    i_perm_b = 3'b010;
    cycles(6);
    n_checks++;
    if (o_sb_on_b !== 1'b1 || o_fault !== 1'b0 || o_anode_en !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_debounced sb_on_b=%b fault=%b anode=%b want 1 0 1", o_sb_on_b, o_fault, o_anode_en);
    end
    cycles(1);
    n_checks++;
    if (outs() !== 12'b10_0001_001_010) begin
      n_fail++;
      $display("FAIL fault_entry got=%b want=%b", outs(), 12'b10_0001_001_010);
    end
    i_perm_b = 3'b110;
    cycles(8);
    n_checks++;
    if (o_fault_src !== 3'b010) begin
      n_fail++;
      $display("FAIL fault_src_hold got=%b want=010", o_fault_src);
    end
    i_hv_req = 1'b0;
    i_fault_clr = 1'b1;
    cycles(1);
    i_fault_clr = 1'b0;
    n_checks++;
    if (o_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_clr_perm_bad fault=%b want 1", o_fault);
    end
    i_perm_b = 3'b000;
    i_hv_req = 1'b1;
    cycles(8);
    i_fault_clr = 1'b1;
    cycles(1);
    i_fault_clr = 1'b0;
    n_checks++;
    if (o_fault !== 1'b1 || o_g2_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clr_hv_req fault=%b g2=%b want 1 0", o_fault, o_g2_en);
    end
    i_hv_req = 1'b0;
    cycles(1);
    i_fault_clr = 1'b1;
    cycles(1);
    i_fault_clr = 1'b0;
    n_checks++;
    if (outs() !== 12'b01_0001_000_000) begin
      n_fail++;
      $display("FAIL fault_clear got=%b want=%b", outs(), 12'b01_0001_000_000);
    end
    $display("test_fault done");
  endtask

  task automatic test_reset_in_run();
    i_hv_req = 1'b1;
    cycles(10);
    n_checks++;
    if (o_anode_en !== 1'b1 || o_rf_perm !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_run_setup anode=%b rf=%b want 1 1", o_anode_en, o_rf_perm);
    end
    reset = 1'b1;
    cycles(1);
    n_checks++;
    if (outs() !== 12'b10_0001_000_000) begin
      n_fail++;
      $display("FAIL reset_in_run got=%b want=%b", outs(), 12'b10_0001_000_000);
    end
    reset = 1'b0;
    i_hv_req = 1'b0;
    cycles(2);
    $display("test_reset_in_run done");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_ramp_up();
    test_ramp_down();
    test_abort();
    test_idle_no_fault();
    test_fault();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
